// File: rtl/drac_pkg.sv
// Shared types and constants for the data-cache request arbiter and its
// HPDC-facing request/response payloads.
package drac_pkg;

  localparam int unsigned HPDC_ADDR_W = 40;
  localparam int unsigned HPDC_DATA_W = 64;
  localparam int unsigned HPDC_BE_W   = HPDC_DATA_W / 8;
  localparam int unsigned HPDC_SID_W  = 3;
  localparam int unsigned HPDC_TID_W  = 8;

  localparam int unsigned DCACHE_ARB_NUM_REQ  = 3;
  localparam int unsigned DCACHE_ARB_NUM_TAGS = 16;
  localparam int unsigned ARB_OWNER_W         = $clog2(DCACHE_ARB_NUM_REQ);

  localparam int unsigned ARB_LSU   = 0;
  localparam int unsigned ARB_PTW   = 1;
  localparam int unsigned ARB_SPARE = 2;

  typedef enum logic [1:0] {
    HPDC_LOAD  = 2'd0,
    HPDC_STORE = 2'd1,
    HPDC_AMO   = 2'd2,
    HPDC_CMO   = 2'd3
  } hpdcache_op_e;

  typedef struct packed {
    logic [HPDC_ADDR_W-1:0] addr;
    logic [HPDC_DATA_W-1:0] wdata;
    hpdcache_op_e           op;
    logic [HPDC_BE_W-1:0]   be;
    logic [2:0]             size;
    logic [HPDC_SID_W-1:0]  sid;
    logic [HPDC_TID_W-1:0]  tid;
    logic                   need_rsp;
  } hpdcache_req_t;

  typedef struct packed {
    logic [HPDC_DATA_W-1:0] rdata;
    logic [HPDC_SID_W-1:0]  sid;
    logic [HPDC_TID_W-1:0]  tid;
    logic                   error;
    logic                   aborted;
  } hpdcache_rsp_t;

  // One tag-table entry: who owns the tag and what to restore on response.
  typedef struct packed {
    logic                   busy;
    logic [ARB_OWNER_W-1:0] owner;
    logic [HPDC_TID_W-1:0]  orig_tid;
    logic                   need_rsp;
  } dcache_arb_entry_t;

endpackage

// File: rtl/dcache_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_q, and
// moves the pointer past the winner only when enable_i reports an accept.
module dcache_rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [N-1:0]     req_i,
  input  logic             enable_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] rr_q, rr_d;
  int unsigned      cand;
  logic             found;

  // NOTE: every signal written here gets a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = 32'(rr_q) + off;
      if (cand >= N) cand = cand - N;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (enable_i) rr_d = (idx_o == IDX_W'(N - 1)) ? '0 : idx_o + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) rr_q <= '0;
    else         rr_q <= rr_d;
  end

endmodule

// File: rtl/dcache_req_arbiter.sv
// Shares the HPDC core request port among NUM_REQ requesters, renaming each
// request tid to an internal tag and restoring it on the response path.
module dcache_req_arbiter
  import drac_pkg::*;
#(
  parameter int unsigned           NUM_REQ  = DCACHE_ARB_NUM_REQ,
  parameter int unsigned           NUM_TAGS = DCACHE_ARB_NUM_TAGS,
  parameter logic [HPDC_SID_W-1:0] SID      = 3'b001
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  hpdcache_req_t                 req_i [NUM_REQ],
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output hpdcache_rsp_t                 rsp_o,
  output logic                          core_req_valid_o,
  output hpdcache_req_t                 req_dcache_o,
  input  logic                          dcache_ready_i,
  input  logic                          dcache_valid_i,
  input  hpdcache_rsp_t                 rsp_dcache_i,
  output logic [$clog2(NUM_TAGS+1)-1:0] inflight_o,
  output logic                          idle_o,
  output logic                          err_o
);

  localparam int unsigned REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TAG_W = $clog2(NUM_TAGS);
  localparam int unsigned CNT_W = $clog2(NUM_TAGS + 1);

  dcache_arb_entry_t table_q [NUM_TAGS];
  dcache_arb_entry_t table_d [NUM_TAGS];
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic              err_q, err_d;

  logic [NUM_REQ-1:0] grant;
  logic [REQ_W-1:0]   win_idx;
  logic [TAG_W-1:0]   free_tag;
  logic               full;
  logic               accept;

  logic [TAG_W-1:0]   rsp_tag;
  logic               rsp_in_range;
  logic               rsp_hit;
  dcache_arb_entry_t  rsp_entry;

  dcache_rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .req_i    (req_valid_i),
    .enable_i (accept),
    .grant_o  (grant),
    .idx_o    (win_idx)
  );

  // Lowest free tag wins; the scan reads only registered state, so a tag
  // released this cycle becomes allocatable on the next one.
  always_comb begin
    free_tag = '0;
    full     = 1'b1;
    for (int t = NUM_TAGS - 1; t >= 0; t--) begin
      if (!table_q[t].busy) begin
        free_tag = TAG_W'(t);
        full     = 1'b0;
      end
    end
  end

  always_comb begin
    req_dcache_o          = req_i[win_idx];
    req_dcache_o.tid      = HPDC_TID_W'(free_tag);
    req_dcache_o.sid      = SID;
    req_dcache_o.need_rsp = 1'b1;
  end

  assign core_req_valid_o = (|req_valid_i) & ~full;
  assign req_ready_o      = grant & {NUM_REQ{~full & dcache_ready_i}};
  assign accept           = core_req_valid_o & dcache_ready_i;

  // Tids beyond the table range can never name a live tag.
  assign rsp_tag      = rsp_dcache_i.tid[TAG_W-1:0];
  assign rsp_in_range = (rsp_dcache_i.tid >> TAG_W) == '0;
  assign rsp_entry    = table_q[rsp_tag];
  assign rsp_hit      = dcache_valid_i & rsp_in_range & rsp_entry.busy;

  always_comb begin
    rsp_valid_o = '0;
    if (rsp_hit && rsp_entry.need_rsp) rsp_valid_o[rsp_entry.owner] = 1'b1;
  end

  always_comb begin
    rsp_o     = rsp_dcache_i;
    rsp_o.tid = rsp_entry.orig_tid;
  end

  always_comb begin
    table_d = table_q;
    if (rsp_hit) table_d[rsp_tag].busy = 1'b0;
    if (accept) begin
      table_d[free_tag] = '{
        busy:     1'b1,
        owner:    ARB_OWNER_W'(win_idx),
        orig_tid: req_i[win_idx].tid,
        need_rsp: req_i[win_idx].need_rsp
      };
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case ({accept, rsp_hit})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  assign err_d = err_q | (dcache_valid_i & ~rsp_hit);

  // NOTE: the whole tag table is reset, not just its control bits: a reset
  // mid-operation must forget every outstanding tag so late responses flag err.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      table_q    <= '{default: '0};
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      table_q    <= table_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign inflight_o = inflight_q;
  assign idle_o     = (inflight_q == '0);
  assign err_o      = err_q;

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Self-checking bench for dcache_req_arbiter: directed scenarios plus
// randomized traffic checked against a tag-table reference model.
module tb_dcache_req_arbiter;
  import drac_pkg::*;

  logic          clk = 1'b0;
  logic          rstn;
  logic [2:0]    req_valid;
  hpdcache_req_t req [3];
  logic [2:0]    req_ready;
  logic [2:0]    rsp_valid;
  hpdcache_rsp_t rsp_out;
  logic          core_req_valid;
  hpdcache_req_t req_dcache;
  logic          dcache_ready;
  logic          dcache_valid;
  hpdcache_rsp_t rsp_dcache;
  logic [4:0]    inflight;
  logic          idle;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  dcache_req_arbiter dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .req_valid_i      (req_valid),
    .req_i            (req),
    .req_ready_o      (req_ready),
    .rsp_valid_o      (rsp_valid),
    .rsp_o            (rsp_out),
    .core_req_valid_o (core_req_valid),
    .req_dcache_o     (req_dcache),
    .dcache_ready_i   (dcache_ready),
    .dcache_valid_i   (dcache_valid),
    .rsp_dcache_i     (rsp_dcache),
    .inflight_o       (inflight),
    .idle_o           (idle),
    .err_o            (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req_valid    = '0;
    for (int i = 0; i < 3; i++) req[i] = '0;
    dcache_ready = 1'b1;
    dcache_valid = 1'b0;
    rsp_dcache   = '0;
  endtask

  task automatic apply_reset();
    drive_idle();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    tick();
  endtask

  function automatic hpdcache_req_t rand_req();
    hpdcache_req_t r;
    r.addr     = 40'({$urandom(), $urandom()});
    r.wdata    = {$urandom(), $urandom()};
    r.op       = hpdcache_op_e'($urandom_range(0, 3));
    r.be       = 8'($urandom());
    r.size     = 3'($urandom_range(0, 3));
    r.sid      = 3'($urandom());
    r.tid      = 8'($urandom());
    r.need_rsp = 1'($urandom());
    return r;
  endfunction

  function automatic hpdcache_rsp_t rand_rsp(input logic [7:0] tid);
    hpdcache_rsp_t r;
    r.rdata   = {$urandom(), $urandom()};
    r.sid     = 3'($urandom());
    r.tid     = tid;
    r.error   = 1'($urandom());
    r.aborted = 1'($urandom());
    return r;
  endfunction

  task automatic test_reset();
    drive_idle();
    rstn = 1'b0;
    #3;
    n_checks++;
    if ({req_ready, rsp_valid, core_req_valid, inflight, idle, err} !== {3'b0, 3'b0, 1'b0, 5'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b rspv=%b cv=%b infl=%0d idle=%b err=%b, want 000 000 0 0 1 0",
               req_ready, rsp_valid, core_req_valid, inflight, idle, err);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single_load();
    hpdcache_req_t exp_req;
    hpdcache_rsp_t rsp;
    apply_reset();
    req[0]          = rand_req();
    req[0].tid      = 8'h25;
    req[0].need_rsp = 1'b1;
    req[0].op       = HPDC_LOAD;
    req_valid       = 3'b001;
    exp_req         = req[0];
    exp_req.tid     = 8'h00;
    exp_req.sid     = 3'b001;
    #2;
    n_checks++;
    if ({core_req_valid, req_ready, req_dcache} !== {1'b1, 3'b001, exp_req}) begin
      n_fail++;
      $display("FAIL load_issue: got cv=%b rdy=%b tid=%h sid=%b nr=%b, want 1 001 00 001 1",
               core_req_valid, req_ready, req_dcache.tid, req_dcache.sid, req_dcache.need_rsp);
    end
    tick();
    req_valid = '0;
    #2;
    n_checks++;
    if ({inflight, idle} !== {5'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL load_inflight1: got infl=%0d idle=%b, want 1 0", inflight, idle);
    end
    rsp          = rand_rsp(8'h00);
    rsp_dcache   = rsp;
    dcache_valid = 1'b1;
    rsp.tid      = 8'h25;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_out} !== {3'b001, rsp}) begin
      n_fail++;
      $display("FAIL load_rsp: got rspv=%b tid=%h rdata=%h, want 001 25 %h",
               rsp_valid, rsp_out.tid, rsp_out.rdata, rsp.rdata);
    end
    tick();
    dcache_valid = 1'b0;
    #2;
    n_checks++;
    if ({inflight, idle, err} !== {5'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL load_release: got infl=%0d idle=%b err=%b, want 0 1 0", inflight, idle, err);
    end
  endtask

  // Leaves the table full; test_full_release continues from here.
  task automatic test_fill_rr();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      req[i]          = rand_req();
      req[i].tid      = 8'(8'h40 + i);
      req[i].need_rsp = 1'b1;
    end
    req_valid = 3'b111;
    for (int k = 0; k < 16; k++) begin
      #2;
      n_checks++;
      if ({req_ready, req_dcache.tid, inflight} !== {3'(1 << (k % 3)), 8'(k), 5'(k)}) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got rdy=%b tid=%0d infl=%0d, want %b %0d %0d",
                 k, req_ready, req_dcache.tid, inflight, 3'(1 << (k % 3)), k, k);
      end
      tick();
    end
    #2;
    n_checks++;
    if ({req_ready, core_req_valid, inflight, idle} !== {3'b000, 1'b0, 5'd16, 1'b0}) begin
      n_fail++;
      $display("FAIL full_stall: got rdy=%b cv=%b infl=%0d idle=%b, want 000 0 16 0",
               req_ready, core_req_valid, inflight, idle);
    end
  endtask

  task automatic test_full_release();
    req_valid    = 3'b010;
    req[1].tid   = 8'h11;
    rsp_dcache   = rand_rsp(8'd5);
    dcache_valid = 1'b1;
    #2;
    // Tag 5 was the 6th grant, which went to requester 2 (tid 0x42).
    n_checks++;
    if ({req_ready, core_req_valid, rsp_valid, rsp_out.tid} !== {3'b000, 1'b0, 3'b100, 8'h42}) begin
      n_fail++;
      $display("FAIL release_cycle_n: got rdy=%b cv=%b rspv=%b tid=%h, want 000 0 100 42",
               req_ready, core_req_valid, rsp_valid, rsp_out.tid);
    end
    tick();
    dcache_valid = 1'b0;
    #2;
    n_checks++;
    if ({req_ready, req_dcache.tid, inflight} !== {3'b010, 8'd5, 5'd15}) begin
      n_fail++;
      $display("FAIL reuse_tag5: got rdy=%b tid=%0d infl=%0d, want 010 5 15",
               req_ready, req_dcache.tid, inflight);
    end
    tick();
    req_valid = '0;
    #2;
    n_checks++;
    if (inflight !== 5'd16) begin
      n_fail++;
      $display("FAIL refill_count: got %0d want 16", inflight);
    end
  endtask

  task automatic test_store_no_rsp();
    apply_reset();
    req[1]          = rand_req();
    req[1].op       = HPDC_STORE;
    req[1].tid      = 8'h33;
    req[1].need_rsp = 1'b0;
    req_valid       = 3'b010;
    #2;
    n_checks++;
    if ({req_ready, req_dcache.need_rsp, req_dcache.tid} !== {3'b010, 1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL store_issue: got rdy=%b nr=%b tid=%0d, want 010 1 0",
               req_ready, req_dcache.need_rsp, req_dcache.tid);
    end
    tick();
    req_valid    = '0;
    rsp_dcache   = rand_rsp(8'd0);
    dcache_valid = 1'b1;
    #2;
    n_checks++;
    if (rsp_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL store_rsp_dropped: got rspv=%b want 000", rsp_valid);
    end
    tick();
    dcache_valid = 1'b0;
    #2;
    n_checks++;
    if ({inflight, err} !== {5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL store_release: got infl=%0d err=%b, want 0 0", inflight, err);
    end
  endtask

  task automatic test_err_idle();
    apply_reset();
    rsp_dcache   = rand_rsp(8'd9);
    dcache_valid = 1'b1;
    #2;
    n_checks++;
    if ({rsp_valid, err} !== {3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL err_no_rsp: got rspv=%b err=%b, want 000 0", rsp_valid, err);
    end
    tick();
    dcache_valid = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({err, inflight} !== {1'b1, 5'd0}) begin
      n_fail++;
      $display("FAIL err_sticky: got err=%b infl=%0d, want 1 0", err, inflight);
    end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    for (int i = 0; i < 3; i++) req[i] = rand_req();
    // Three LSU accepts then one PTW accept: pointer ends at 2.
    for (int k = 0; k < 4; k++) begin
      req_valid = (k < 3) ? 3'b001 : 3'b010;
      tick();
    end
    req_valid = '0;
    #1;
    n_checks++;
    if (inflight !== 5'd4) begin
      n_fail++;
      $display("FAIL midop_before: got infl=%0d want 4", inflight);
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({inflight, idle, err, req_ready} !== {5'd0, 1'b1, 1'b0, 3'b000}) begin
      n_fail++;
      $display("FAIL midop_async: got infl=%0d idle=%b err=%b rdy=%b, want 0 1 0 000",
               inflight, idle, err, req_ready);
    end
    rstn = 1'b1;
    tick();
    rsp_dcache   = rand_rsp(8'd2);
    dcache_valid = 1'b1;
    #2;
    n_checks++;
    if (rsp_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL late_rsp_valid: got %b want 000", rsp_valid);
    end
    tick();
    dcache_valid = 1'b0;
    req_valid    = 3'b111;
    #2;
    n_checks++;
    if ({err, req_ready} !== {1'b1, 3'b001}) begin
      n_fail++;
      $display("FAIL late_rsp_err_rr: got err=%b rdy=%b, want 1 001", err, req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    bit            m_busy  [16];
    int            m_owner [16];
    logic [7:0]    m_tid   [16];
    bit            m_need  [16];
    int            m_rr, cnt, free, win, t;
    bit            m_err, full, hit, exp_core;
    logic [2:0]    exp_ready, exp_rsp;
    int            busy_list [$];
    hpdcache_req_t exp_req;
    hpdcache_rsp_t exp_rsp_pl;

    apply_reset();
    m_rr  = 0;
    m_err = 1'b0;
    for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < 3; i++) req[i] = rand_req();
      req_valid    = 3'($urandom());
      dcache_ready = ($urandom_range(0, 3) != 0);
      busy_list.delete();
      for (int i = 0; i < 16; i++) if (m_busy[i]) busy_list.push_back(i);
      dcache_valid = 1'b0;
      rsp_dcache   = rand_rsp(8'($urandom()));
      if (busy_list.size() > 0 && $urandom_range(0, 9) < 4) begin
        rsp_dcache.tid = 8'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
        dcache_valid   = 1'b1;
      end else if ($urandom_range(0, 49) == 0) begin
        dcache_valid = 1'b1;
      end

      cnt  = 0;
      free = -1;
      for (int i = 0; i < 16; i++) begin
        if (m_busy[i]) cnt++;
        else if (free < 0) free = i;
      end
      full = (cnt == 16);
      win  = -1;
      for (int off = 0; off < 3; off++)
        if (win < 0 && req_valid[(m_rr + off) % 3]) win = (m_rr + off) % 3;
      exp_core  = (win >= 0) && !full;
      exp_ready = (exp_core && dcache_ready) ? 3'(1 << win) : 3'b000;
      t         = int'(rsp_dcache.tid);
      hit       = dcache_valid && (t < 16) && m_busy[t % 16];
      exp_rsp   = (hit && m_need[t % 16]) ? 3'(1 << m_owner[t % 16]) : 3'b000;

      #2;
      n_checks++;
      if ({req_ready, core_req_valid, rsp_valid, inflight, idle, err} !==
          {exp_ready, exp_core, exp_rsp, 5'(cnt), cnt == 0, m_err}) begin
        n_fail++;
        $display("FAIL rand_ctl[%0d]: got rdy=%b cv=%b rspv=%b infl=%0d idle=%b err=%b, want %b %b %b %0d %b %b",
                 cyc, req_ready, core_req_valid, rsp_valid, inflight, idle, err,
                 exp_ready, exp_core, exp_rsp, cnt, cnt == 0, m_err);
      end
      if (exp_core) begin
        exp_req          = req[win];
        exp_req.tid      = 8'(free);
        exp_req.sid      = 3'b001;
        exp_req.need_rsp = 1'b1;
        n_checks++;
        if (req_dcache !== exp_req) begin
          n_fail++;
          $display("FAIL rand_req[%0d]: got %h want %h", cyc, req_dcache, exp_req);
        end
      end
      if (exp_rsp != 3'b000) begin
        exp_rsp_pl     = rsp_dcache;
        exp_rsp_pl.tid = m_tid[t % 16];
        n_checks++;
        if (rsp_out !== exp_rsp_pl) begin
          n_fail++;
          $display("FAIL rand_rsp[%0d]: got %h want %h", cyc, rsp_out, exp_rsp_pl);
        end
      end

      if (hit) m_busy[t % 16] = 1'b0;
      if (dcache_valid && !hit) m_err = 1'b1;
      if (exp_core && dcache_ready) begin
        m_busy[free]  = 1'b1;
        m_owner[free] = win;
        m_tid[free]   = req[win].tid;
        m_need[free]  = req[win].need_rsp;
        m_rr          = (win + 1) % 3;
      end
      tick();
    end
    drive_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_load();
    test_fill_rr();
    test_full_release();
    test_store_no_rsp();
    test_err_idle();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
